// File: rtl/arc4_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and key-byte helper for the ARC4 S-array initialiser.
// The key-schedule pass is compiled in only when ARC4_INIT_KSA_EN is defined.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    KS_RDI  = 3'd2,
    KS_CAPI = 3'd3,
    KS_RDJ  = 3'd4,
    KS_CAPJ = 3'd5,
    KS_WRI  = 3'd6,
    KS_WRJ  = 3'd7
  } state_t;

  localparam int unsigned MAX_KEY_BYTES = 32;

  // Byte 0 is the most significant byte of an nbytes-wide key.
  function automatic logic [7:0] key_byte(input logic [8*MAX_KEY_BYTES-1:0] key,
                                          input int unsigned nbytes,
                                          input int unsigned idx);
    key_byte = key[8*(nbytes-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/arc4_ksa_seq.sv
`timescale 1ns/1ps
// ARC4 key-schedule datapath: latched key, running j index and the two
// swap operands si/sj. Only instantiated when ARC4_INIT_KSA_EN is defined.
module arc4_ksa_seq
  import arc4_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   accept_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  state_t                 state_i,
  input  logic [DATA_W-1:0]      rddata_i,
  output logic [ADDR_W-1:0]      j_o,
  output logic [DATA_W-1:0]      si_o,
  output logic [DATA_W-1:0]      sj_o
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [DATA_W-1:0]      si_q, si_d;
  logic [DATA_W-1:0]      sj_q, sj_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [7:0]             kb;

  // kidx tracks i mod KEY_BYTES without a divider: i never wraps mid-pass.
  assign kb = key_byte((8*MAX_KEY_BYTES)'(key_q), KEY_BYTES, 32'(kidx_q));

  always_comb begin
    key_d  = key_q;
    j_d    = j_q;
    si_d   = si_q;
    sj_d   = sj_q;
    kidx_d = kidx_q;
    if (accept_i) begin
      key_d  = key_i;
      j_d    = '0;
      kidx_d = '0;
    end else begin
      case (state_i)
        KS_CAPI: begin
          si_d = rddata_i;
          j_d  = j_q + ADDR_W'(rddata_i) + ADDR_W'(kb);
        end
        KS_CAPJ: sj_d = rddata_i;
        KS_WRJ:  kidx_d = (kidx_q == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= '0;
      j_q    <= '0;
      si_q   <= '0;
      sj_q   <= '0;
      kidx_q <= '0;
    end else begin
      key_q  <= key_d;
      j_q    <= j_d;
      si_q   <= si_d;
      sj_q   <= sj_d;
      kidx_q <= kidx_d;
    end
  end

  assign j_o  = j_q;
  assign si_o = si_q;
  assign sj_o = sj_q;

endmodule

// File: rtl/arc4_init_engine.sv
`timescale 1ns/1ps
// ARC4 S-array initialiser: fills RAM with (i + START_VAL), then optionally
// runs the key-schedule swap pass when ARC4_INIT_KSA_EN is defined.
module arc4_init_engine
  import arc4_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                KEY_BYTES = 3,
  parameter logic [DATA_W-1:0] START_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      wrdata,
  output logic                   wren,
  input  logic [DATA_W-1:0]      rddata,
  output logic [2:0]             dbg_state
);

  // Handshake: a request is taken in any cycle where en && rdy; rdy is high
  // only in IDLE, and en seen while rdy is low is dropped, never queued.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic              accept;
  logic              last_i;

  assign accept    = en && (state_q == IDLE);
  assign last_i    = &i_q;
  assign dbg_state = state_q;

`ifdef ARC4_INIT_KSA_EN
  logic [ADDR_W-1:0] j;
  logic [DATA_W-1:0] si, sj;

  arc4_ksa_seq #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .KEY_BYTES (KEY_BYTES)
  ) u_ksa (
    .clk      (clk),
    .rst      (rst),
    .accept_i (accept),
    .key_i    (key),
    .state_i  (state_q),
    .rddata_i (rddata),
    .j_o      (j),
    .si_o     (si),
    .sj_o     (sj)
  );
`else
  logic unused_ksa_inputs;
  assign unused_ksa_inputs = ^{key, rddata};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FILL;
          i_d     = '0;
        end
      end
      FILL: begin
        i_d = i_q + 1'b1;
`ifdef ARC4_INIT_KSA_EN
        if (last_i) state_d = KS_RDI;
`else
        if (last_i) state_d = IDLE;
`endif
      end
`ifdef ARC4_INIT_KSA_EN
      KS_RDI:  state_d = KS_CAPI;
      KS_CAPI: state_d = KS_RDJ;
      KS_RDJ:  state_d = KS_CAPJ;
      KS_CAPJ: state_d = KS_WRI;
      KS_WRI:  state_d = KS_WRJ;
      KS_WRJ: begin
        i_d     = i_q + 1'b1;
        state_d = last_i ? IDLE : KS_RDI;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // j is a register, so there is no combinational path from rddata to addr.
  always_comb begin
    rdy    = 1'b0;
    addr   = '0;
    wrdata = '0;
    wren   = 1'b0;
    case (state_q)
      IDLE: rdy = 1'b1;
      FILL: begin
        addr   = i_q;
        wrdata = DATA_W'(i_q) + START_VAL;
        wren   = 1'b1;
      end
`ifdef ARC4_INIT_KSA_EN
      KS_RDI: addr = i_q;
      KS_RDJ: addr = j;
      KS_WRI: begin
        addr   = i_q;
        wrdata = sj;
        wren   = 1'b1;
      end
      KS_WRJ: begin
        addr   = j;
        wrdata = si;
        wren   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arc4_init_engine.sv
`timescale 1ns/1ps
// Directed bench for arc4_init_engine: default 8-bit instance plus a 4-bit
// instance with a 0xF0 fill offset; honours ARC4_INIT_KSA_EN when defined.
module tb_arc4_init_engine;

  logic        clk;
  logic        rst;
  logic        en, en_s;
  logic [23:0] key, key_s;
  logic        rdy, rdy_s;
  logic [7:0]  addr;
  logic [3:0]  addr_s;
  logic [7:0]  wrdata, wrdata_s;
  logic        wren, wren_s;
  logic [7:0]  rddata, rddata_s;
  logic [2:0]  dbg, dbg_s;

  logic [7:0]  mem [256];
  logic [7:0]  mem_s [16];

  int tests = 0;
  int fails = 0;
  int cnt, wr, n;
  logic [7:0] s_ref [256];
  logic [7:0] kb_ref [3];
  logic [7:0] jj, tmp;

  arc4_init_engine dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .addr(addr),
    .wrdata(wrdata), .wren(wren), .rddata(rddata), .dbg_state(dbg)
  );

  arc4_init_engine #(.ADDR_W(4), .DATA_W(8), .KEY_BYTES(3), .START_VAL(8'hF0)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .rdy(rdy_s), .key(key_s), .addr(addr_s),
    .wrdata(wrdata_s), .wren(wren_s), .rddata(rddata_s), .dbg_state(dbg_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port RAM models with one-cycle read latency
  always @(posedge clk) begin
    if (wren) mem[addr] <= wrdata;
    rddata <= mem[addr];
    if (wren_s) mem_s[addr_s] <= wrdata_s;
    rddata_s <= mem_s[addr_s];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; en_s = 1'b0;
    key = 24'h00033C; key_s = 24'h0A0B0C;

    // reset pulse of 100 ps, checked during and after
    #2 rst = 1'b1;
    #0.05;
    check("rst_during", {rdy, wren, addr, dbg}, {1'b1, 1'b0, 8'h00, 3'd0});
    check("rst_during_s", {rdy_s, wren_s, addr_s, dbg_s}, {1'b1, 1'b0, 4'h0, 3'd0});
    #0.05 rst = 1'b0;
    #1;
    check("rst_after", {rdy, wren, addr, wrdata}, {1'b1, 1'b0, 8'h00, 8'h00});

    // default fill: one-cycle en, key changed after accept
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0; key = 24'hFFFFFF;
    check("fill_state", 32'(dbg), 32'd1);
    for (int k = 0; k < 256; k++) begin
      check("fill_a", {rdy, wren, addr, wrdata}, {1'b0, 1'b1, 8'(k), 8'(k)});
      @(negedge clk);
    end
`ifdef ARC4_INIT_KSA_EN
    cnt = 0;
    while (!rdy && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    check("ksa_cycles", 32'(cnt), 32'd1536);
    kb_ref = '{8'h00, 8'h03, 8'h3C};
    for (int i = 0; i < 256; i++) s_ref[i] = 8'(i);
    jj = 8'h00;
    for (int i = 0; i < 256; i++) begin
      jj = jj + s_ref[i] + kb_ref[i % 3];
      tmp = s_ref[i]; s_ref[i] = s_ref[jj]; s_ref[jj] = tmp;
    end
    for (int a = 0; a < 256; a++) check("ksa_mem", 32'(mem[a]), 32'(s_ref[a]));
`else
    check("fill_done", {rdy, wren}, {1'b1, 1'b0});
    for (int a = 0; a < 256; a++) check("fill_mem", 32'(mem[a]), a);
`endif

    // small instance with fill offset
    @(negedge clk); en_s = 1'b1;
    @(negedge clk); en_s = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("fill_s", {rdy_s, wren_s, addr_s, wrdata_s}, {1'b0, 1'b1, 4'(k), 8'(8'hF0 + k)});
      @(negedge clk);
    end
    check("wrap_s", 32'(addr_s), 32'd0);
`ifdef ARC4_INIT_KSA_EN
    cnt = 0;
    while (!rdy_s && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("ksa_cycles_s", 32'(cnt), 32'd96);
`else
    check("done_s", {rdy_s, wren_s}, {1'b1, 1'b0});
`endif

    // en held high: exactly one run, next run starts when rdy returns
    @(negedge clk); en = 1'b1;
    @(negedge clk);
    cnt = 0; wr = 0;
    while (!rdy && cnt < 3000) begin
      cnt++;
      if (wren) wr++;
      @(negedge clk);
    end
`ifdef ARC4_INIT_KSA_EN
    check("held_len", 32'(cnt), 32'd1792);
    check("held_writes", 32'(wr), 32'd768);
`else
    check("held_len", 32'(cnt), 32'd256);
    check("held_writes", 32'(wr), 32'd256);
`endif
    @(negedge clk); en = 1'b0;
    check("rerun_start", {rdy, wren, addr}, {1'b0, 1'b1, 8'h00});

    // reset at fill address 100, then restart
    n = 0;
    while (!(wren && addr == 8'd100) && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("reach_100", {wren, addr}, {1'b1, 8'd100});
    #1 rst = 1'b1;
    #1;
    check("midrst", {rdy, wren, addr, wrdata}, {1'b1, 1'b0, 8'h00, 8'h00});
    #1 rst = 1'b0;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    check("restart0", {rdy, wren, addr, wrdata}, {1'b0, 1'b1, 8'h00, 8'h00});
    @(negedge clk);
    check("restart1", {wren, addr, wrdata}, {1'b1, 8'h01, 8'h01});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arc4_init_engine.md
# arc4_init_engine

Parametrised S-array initialiser for the ARC4 datapath. On an accepted request it fills an external single-port RAM with s[i] = (i + START_VAL) mod 2^DATA_W for every address. When the key-schedule pass is compiled in, it then runs the ARC4 swap pass using a latched key. It sits between the top-level controller and the S memory, and replaces the fixed 256-entry identity fill.

## Interface
- ADDR_W, default 8: address width; depth = 2^ADDR_W.
- DATA_W, default 8: word width; must be ≥ ADDR_W.
- KEY_BYTES, default 3: key length in bytes.
- START_VAL, default 0: fill offset, DATA_W bits.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  idle and able to accept a request.
- key  in  8*KEY_BYTES  ARC4 key; byte 0 = most significant byte; latched on accept.
- addr  out  ADDR_W  RAM address.
- wrdata  out  DATA_W  RAM write data.
- wren  out  1  RAM write enable.
- rddata  in  DATA_W  RAM read data; valid the cycle after addr is presented.

## Operation
- Reset values: rdy=1, wren=0, addr=0, wrdata=0. State = IDLE, counters i=0 and j=0.
- IDLE: if en && rdy, latch key, clear i and j, go to FILL. Otherwise hold.
- FILL: each cycle, addr=i, wrdata=i+START_VAL (mod 2^DATA_W), wren=1, then i++.
  - After the write to i = 2^ADDR_W−1, i wraps to 0.
  - Next state is KS_RDI if KSA_EN is defined, else IDLE.
- Key-schedule states, one pass per i (6 cycles):
  - KS_RDI: addr=i.
  - KS_CAPI: si←rddata; j←(j + si + key byte (i mod KEY_BYTES)), all mod 2^ADDR_W. si is truncated to ADDR_W bits; the key byte is zero-extended or truncated to ADDR_W bits.
  - KS_RDJ: addr=j.
  - KS_CAPJ: sj←rddata.
  - KS_WRI: addr=i, wrdata=sj, wren=1.
  - KS_WRJ: addr=j, wrdata=si, wren=1. Then i++. If i wrapped to 0, go to IDLE; else go to KS_RDI.
- When i==j, both writes go to the same address; the final content is si, which is correct.
- wren is 0 in every state except FILL, KS_WRI and KS_WRJ.
- en asserted while rdy=0 is ignored and is not queued.
- Changes on key after accept have no effect.
- rst asserted mid-operation: outputs return to reset values immediately. RAM content is then undefined; a new request restarts from i=0.

## Timing
- en high in accept cycle N:
  - rdy=0 from N+1.
  - First FILL write at N+1.
  - Last FILL write at N+2^ADDR_W.
- Without KSA_EN: rdy=1 at N+2^ADDR_W+1. Earliest re-accept is in that cycle.
- With KSA_EN: the key pass adds 6·2^ADDR_W cycles. rdy=1 at N+7·2^ADDR_W+1.
- No combinational path from rddata to addr; j is registered before use.

## Configuration
- ARC4_INIT_KSA_EN:
  - Defined: the key-schedule states, key latch, j register and si/sj registers are built; the fill is followed by the swap pass.
  - Undefined: only IDLE and FILL exist; key is unused; completion is at end of fill.

## Structure
- arc4_pkg: state enum (IDLE, FILL, KS_RDI, KS_CAPI, KS_RDJ, KS_CAPJ, KS_WRI, KS_WRJ) and a key_byte helper function.
- Sub-module arc4_ksa_seq: holds j, si, sj and the key-byte select. Instantiated only under ARC4_INIT_KSA_EN.
- Top holds the i counter, handshake and RAM port mux.

## Test plan
- Reset with rst pulsed 100 ps → rdy=1, wren=0, addr=0 during and after reset.
- Defaults, macro off, en for 1 cycle → 256 consecutive writes with addr=wrdata=0..255; rdy=0 for 256 cycles, then rdy=1.
- ADDR_W=4, START_VAL=8'hF0 → 16 writes, wrdata F0..FF, addr wraps to 0; rdy returns after 16 cycles.
- Macro on, key=24'h00033C → final RAM equals the software ARC4 KSA for that key; rdy returns at N+1793.
- en held high throughout a run → exactly one run; a second run begins only in the cycle rdy returns to 1.
- rst asserted at fill address 100 → wren=0 and rdy=1 immediately; next en → writes restart at addr 0.
